// File: rtl/frame_buf_sched.sv
// Frame-buffer ring scheduler: hands DRAM writer and display the base address of their buffers.
// Build option FBSCHED_STATS_EN adds the dropped/repeated frame counters.
//   state | meaning
//   IDLE  | not scheduling; events ignored, outputs hold
//   RUN   | writer/display events update ring indices and addresses
module frame_buf_sched #(
  parameter int NBUF  = 3,
  parameter int IDX_W = 2
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      cfg_base,
  input  logic [31:0]      cfg_frame_bytes,
  input  logic             wr_frame_done,
  input  logic             rd_frame_req,
  output logic [31:0]      wr_base,
  output logic             wr_base_load,
  output logic [31:0]      rd_base,
  output logic             rd_base_load,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx,
  output logic             running,
  output logic [31:0]      frames_dropped,
  output logic [31:0]      frames_repeated
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d, stride_q, stride_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rdy_idx_q, rdy_idx_d, free_idx;
  logic             rdy_vld_q, rdy_vld_d;
  logic [31:0]      wr_base_q, wr_base_d, rd_base_q, rd_base_d;
  logic             wr_load_q, wr_load_d, rd_load_q, rd_load_d;
  logic             do_init;

  // base + idx*stride as a shift-add over the index bits
  function automatic logic [31:0] buf_addr(input logic [31:0] base, input logic [31:0] stride,
                                           input logic [IDX_W-1:0] idx);
    logic [31:0] acc;
    acc = base;
    for (int i = 0; i < IDX_W; i++)
      if (idx[i]) acc = acc + (stride << i);
    return acc;
  endfunction

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    stride_d  = stride_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    rdy_idx_d = rdy_idx_q;
    rdy_vld_d = rdy_vld_q;
    wr_base_d = wr_base_q;
    rd_base_d = rd_base_q;
    wr_load_d = 1'b0;
    rd_load_d = 1'b0;
    free_idx  = '0;
    do_init   = 1'b0;
    case (state_q)
      ST_IDLE: if (start && !stop) do_init = 1'b1;
      ST_RUN: begin
        if (stop) state_d = ST_IDLE;
        else if (start) do_init = 1'b1;
        else begin
          if (wr_frame_done) begin
            rdy_idx_d = wr_idx_q;
            rdy_vld_d = 1'b1;
          end
          if (rd_frame_req) begin
            rd_load_d = 1'b1;
            if (rdy_vld_d) begin
              rd_idx_d  = rdy_idx_d;
              rdy_vld_d = 1'b0;
              rd_base_d = buf_addr(base_q, stride_q, rdy_idx_d);
            end
          end
          if (wr_frame_done) begin
            // scan downward so the lowest free index is the one left standing
            for (int i = NBUF - 1; i >= 0; i--)
              if (IDX_W'(i) != rd_idx_d && !(rdy_vld_d && IDX_W'(i) == rdy_idx_d))
                free_idx = IDX_W'(i);
            wr_idx_d  = free_idx;
            wr_base_d = buf_addr(base_q, stride_q, free_idx);
            wr_load_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_init) begin
      state_d   = ST_RUN;
      base_d    = cfg_base;
      stride_d  = cfg_frame_bytes;
      wr_idx_d  = '0;
      rd_idx_d  = IDX_W'(NBUF - 1);
      rdy_vld_d = 1'b0;
      wr_base_d = cfg_base;
      rd_base_d = buf_addr(cfg_base, cfg_frame_bytes, IDX_W'(NBUF - 1));
      wr_load_d = 1'b1;
      rd_load_d = 1'b1;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= IDX_W'(NBUF - 1);
      rdy_idx_q <= '0;
      rdy_vld_q <= 1'b0;
      wr_base_q <= '0;
      rd_base_q <= '0;
      wr_load_q <= 1'b0;
      rd_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      rdy_idx_q <= rdy_idx_d;
      rdy_vld_q <= rdy_vld_d;
      wr_base_q <= wr_base_d;
      rd_base_q <= rd_base_d;
      wr_load_q <= wr_load_d;
      rd_load_q <= rd_load_d;
    end
  end

  assign wr_base      = wr_base_q;
  assign rd_base      = rd_base_q;
  assign wr_base_load = wr_load_q;
  assign rd_base_load = rd_load_q;
  assign wr_idx       = wr_idx_q;
  assign rd_idx       = rd_idx_q;
  assign running      = (state_q == ST_RUN);

`ifdef FBSCHED_STATS_EN
  logic [31:0] drop_q, rep_q;
  logic        ev_ok, drop_inc, rep_inc;

  // a request only repeats when no frame was ready before or during this cycle
  assign ev_ok    = (state_q == ST_RUN) && !stop && !start;
  assign drop_inc = ev_ok && wr_frame_done && rdy_vld_q;
  assign rep_inc  = ev_ok && rd_frame_req && !wr_frame_done && !rdy_vld_q;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      rep_q  <= '0;
    end else begin
      if (drop_inc && drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
      if (rep_inc && rep_q != 32'hFFFF_FFFF) rep_q <= rep_q + 32'd1;
    end
  end

  assign frames_dropped  = drop_q;
  assign frames_repeated = rep_q;
`else
  assign frames_dropped  = 32'h0;
  assign frames_repeated = 32'h0;
`endif

  a_no_collide: assert property (@(posedge fclk) disable iff (!rst_n)
    (state_q == ST_RUN) |-> (wr_idx_q != rd_idx_q && !(rdy_vld_q && wr_idx_q == rdy_idx_q)));

endmodule

// File: tb/tb_frame_buf_sched.sv
// Bench for frame_buf_sched: directed vector table, hand sequences, then random traffic vs a model.
module tb_frame_buf_sched;
  localparam int NBUF  = 3;
  localparam int IDX_W = 2;
  localparam logic [31:0] CB = 32'h1000_0000;
  localparam logic [31:0] CF = 32'h0004_B000;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h1004_B000;
  localparam logic [31:0] A2 = 32'h1009_6000;

  logic fclk = 1'b0, rst_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, wfd = 1'b0, rfr = 1'b0;
  logic [31:0] cfg_base = '0, cfg_fb = '0;
  logic [31:0] wr_base, rd_base, frames_dropped, frames_repeated;
  logic wr_base_load, rd_base_load, running;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  always #5 fclk = ~fclk;

  frame_buf_sched #(.NBUF(NBUF), .IDX_W(IDX_W)) dut (
    .fclk(fclk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_base(cfg_base), .cfg_frame_bytes(cfg_fb),
    .wr_frame_done(wfd), .rd_frame_req(rfr),
    .wr_base(wr_base), .wr_base_load(wr_base_load),
    .rd_base(rd_base), .rd_base_load(rd_base_load),
    .wr_idx(wr_idx), .rd_idx(rd_idx), .running(running),
    .frames_dropped(frames_dropped), .frames_repeated(frames_repeated));

  typedef struct {
    bit s, p, w, r;
    int e_wr, e_rd;
    logic [31:0] e_wb, e_rb;
    bit e_wl, e_rl, e_run;
    int e_drop, e_rep;
  } vec_t;
  vec_t tbl[16];

  int n_vec = 0, n_err = 0;

  // model state: plain integers for ring positions, ready slot as valid+index
  bit m_run, m_rv, m_wl, m_rl;
  int m_wr, m_rd, m_ri;
  logic [31:0] m_base, m_fb, m_wb, m_rb, m_drop, m_rep;

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef FBSCHED_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_addr(input int idx);
    return m_base + m_fb * 32'(idx);
  endfunction

  task automatic model_reset();
    m_run = 0; m_rv = 0; m_wl = 0; m_rl = 0;
    m_wr = 0; m_rd = NBUF - 1; m_ri = 0;
    m_wb = '0; m_rb = '0; m_drop = '0; m_rep = '0;
  endtask

  task automatic model_init(input logic [31:0] cb, input logic [31:0] cf);
    m_run = 1; m_base = cb; m_fb = cf;
    m_wr = 0; m_rd = NBUF - 1; m_rv = 0;
    m_wb = m_addr(0); m_rb = m_addr(NBUF - 1);
    m_wl = 1; m_rl = 1;
  endtask

  task automatic model_step(input bit s, input bit p, input bit w, input bit r,
                            input logic [31:0] cb, input logic [31:0] cf);
    m_wl = 0; m_rl = 0;
    if (!m_run) begin
      if (s && !p) model_init(cb, cf);
    end else if (p) m_run = 0;
    else if (s) model_init(cb, cf);
    else begin
      if (w) begin
        if (m_rv && m_drop != 32'hFFFF_FFFF) m_drop++;
        m_ri = m_wr; m_rv = 1;
      end
      if (r) begin
        m_rl = 1;
        if (m_rv) begin
          m_rd = m_ri; m_rv = 0; m_rb = m_addr(m_rd);
        end else if (m_rep != 32'hFFFF_FFFF) m_rep++;
      end
      if (w) begin
        for (int i = 0; i < NBUF; i++)
          if (i != m_rd && !(m_rv && i == m_ri)) begin m_wr = i; break; end
        m_wb = m_addr(m_wr); m_wl = 1;
      end
    end
  endtask

  task automatic cyc(input bit s, input bit p, input bit w, input bit r,
                     input logic [31:0] cb, input logic [31:0] cf);
    @(negedge fclk);
    start = s; stop = p; wfd = w; rfr = r; cfg_base = cb; cfg_fb = cf;
    @(posedge fclk);
    #1;
    model_step(s, p, w, r, cb, cf);
  endtask

  task automatic check_model(input string tag);
    check({tag, " wr_idx"}, 32'(wr_idx), 32'(m_wr));
    check({tag, " rd_idx"}, 32'(rd_idx), 32'(m_rd));
    check({tag, " wr_base"}, wr_base, m_wb);
    check({tag, " rd_base"}, rd_base, m_rb);
    check({tag, " wr_load"}, 32'(wr_base_load), 32'(m_wl));
    check({tag, " rd_load"}, 32'(rd_base_load), 32'(m_rl));
    check({tag, " running"}, 32'(running), 32'(m_run));
    check({tag, " dropped"}, frames_dropped, exp_cnt(m_drop));
    check({tag, " repeated"}, frames_repeated, exp_cnt(m_rep));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " wr_idx"}, 32'(wr_idx), 32'd0);
    check({tag, " rd_idx"}, 32'(rd_idx), 32'(NBUF - 1));
    check({tag, " wr_base"}, wr_base, 32'h0);
    check({tag, " rd_base"}, rd_base, 32'h0);
    check({tag, " loads"}, {30'd0, wr_base_load, rd_base_load}, 32'd0);
    check({tag, " running"}, 32'(running), 32'd0);
    check({tag, " dropped"}, frames_dropped, 32'h0);
    check({tag, " repeated"}, frames_repeated, 32'h0);
  endtask

  initial begin
    bit s, p, w, r;
    logic [31:0] cb, cf;

    tbl[0]  = '{1,0,0,0, 0,2, A0,A2, 1,1,1, 0,0};
    tbl[1]  = '{0,0,0,0, 0,2, A0,A2, 0,0,1, 0,0};
    tbl[2]  = '{0,0,1,0, 1,2, A1,A2, 1,0,1, 0,0};
    tbl[3]  = '{0,0,0,0, 1,2, A1,A2, 0,0,1, 0,0};
    tbl[4]  = '{0,0,0,0, 1,2, A1,A2, 0,0,1, 0,0};
    tbl[5]  = '{0,0,0,0, 1,2, A1,A2, 0,0,1, 0,0};
    tbl[6]  = '{0,0,0,0, 1,2, A1,A2, 0,0,1, 0,0};
    tbl[7]  = '{0,0,0,1, 1,0, A1,A0, 0,1,1, 0,0};
    tbl[8]  = '{0,0,1,1, 0,1, A0,A1, 1,1,1, 0,0};
    tbl[9]  = '{0,0,1,0, 2,1, A2,A1, 1,0,1, 0,0};
    tbl[10] = '{0,0,1,0, 0,1, A0,A1, 1,0,1, 1,0};
    tbl[11] = '{0,0,0,1, 0,2, A0,A2, 0,1,1, 1,0};
    tbl[12] = '{0,0,0,1, 0,2, A0,A2, 0,1,1, 1,1};
    tbl[13] = '{0,0,0,1, 0,2, A0,A2, 0,1,1, 1,2};
    tbl[14] = '{0,1,0,0, 0,2, A0,A2, 0,0,0, 1,2};
    tbl[15] = '{0,0,1,0, 0,2, A0,A2, 0,0,0, 1,2};

    #1 rst_n = 1'b0;
    model_reset();
    #10 check_reset("por");
    @(negedge fclk) rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].s, tbl[i].p, tbl[i].w, tbl[i].r, CB, CF);
      check($sformatf("v%0d wr_idx", i), 32'(wr_idx), 32'(tbl[i].e_wr));
      check($sformatf("v%0d rd_idx", i), 32'(rd_idx), 32'(tbl[i].e_rd));
      check($sformatf("v%0d wr_base", i), wr_base, tbl[i].e_wb);
      check($sformatf("v%0d rd_base", i), rd_base, tbl[i].e_rb);
      check($sformatf("v%0d wr_load", i), 32'(wr_base_load), 32'(tbl[i].e_wl));
      check($sformatf("v%0d rd_load", i), 32'(rd_base_load), 32'(tbl[i].e_rl));
      check($sformatf("v%0d running", i), 32'(running), 32'(tbl[i].e_run));
      check($sformatf("v%0d dropped", i), frames_dropped, exp_cnt(32'(tbl[i].e_drop)));
      check($sformatf("v%0d repeated", i), frames_repeated, exp_cnt(32'(tbl[i].e_rep)));
    end

    // restart from IDLE keeps counters, then asynchronous reset mid-RUN
    cyc(1, 0, 0, 0, CB, CF);  check_model("restart");
    cyc(0, 0, 1, 0, CB, CF);  check_model("run_wfd");
    @(negedge fclk);
    start = 0; stop = 0; wfd = 0; rfr = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset("async_rst");
    @(negedge fclk) rst_n = 1'b1;

    // stop wins over start, both from IDLE and from RUN
    cyc(1, 1, 0, 0, CB, CF);  check_model("idle_stop_start");
    check("idle_stop_start idle", 32'(running), 32'd0);
    cyc(1, 0, 0, 0, CB, CF);  check_model("start2");
    cyc(0, 0, 0, 1, CB, CF);  check_model("repeat_run");
    cyc(1, 1, 1, 1, 32'hDEAD_0000, 32'h80);  check_model("run_stop_start");

    // random traffic with occasional restarts under fresh configuration
    cb = $urandom; cf = $urandom & 32'hFFFF_FF80;
    for (int k = 0; k < 800; k++) begin
      s = running ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 79) == 0);
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 3) == 0);
      if (s) begin cb = $urandom; cf = $urandom & 32'hFFFF_FF80; end
      cyc(s, p, w, r, cb, cf);
      check_model($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_buf_sched.md
Name: frame_buf_sched

Overview:
- Frame-buffer scheduler for the camera-to-DRAM-to-VGA path.
- Owns a ring of NBUF frame buffers in DRAM. Hands the DRAM writer a base address for each new camera frame, and hands the display a base address at each display frame start.
- Triple-buffer policy: the writer never targets the buffer being scanned out. The display always takes the newest completed frame.
- Sits between the MMIO slave (config, start/stop) and the DRAM writer / display address inputs, in the fclk domain.

Parameters:
- NBUF, 3, number of frame buffers; legal range 3..4.
- IDX_W, 2, width of buffer index.

Ports:
- fclk  in  1  system clock (FCLK0).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command: initialise ring and begin scheduling.
- stop  in  1  one-cycle command: stop scheduling.
- cfg_base  in  32  byte address of buffer 0; sampled on start.
- cfg_frame_bytes  in  32  bytes per frame (buffer stride); sampled on start; multiple of 128.
- wr_frame_done  in  1  pulse: writer finished the last burst of the current frame.
- rd_frame_req  in  1  pulse: display is at vsync and needs a frame base.
- wr_base  out  32  base address for the writer's current/next frame.
- wr_base_load  out  1  one-cycle strobe: writer latches wr_base.
- rd_base  out  32  base address for display scan-out.
- rd_base_load  out  1  one-cycle strobe: display latches rd_base.
- wr_idx  out  IDX_W  buffer index being written.
- rd_idx  out  IDX_W  buffer index being displayed.
- running  out  1  high in RUN state.
- frames_dropped  out  32  completed frames overwritten before display.
- frames_repeated  out  32  display requests that reused the previous buffer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - wr_idx=0, rd_idx=NBUF-1, ready_valid=0, ready_idx=0.
  - wr_base=0, rd_base=0, both load strobes 0, running=0, counters 0.
- States are IDLE and RUN.
- IDLE:
  - start: latch cfg_base and cfg_frame_bytes; set wr_idx=0, rd_idx=NBUF-1, ready_valid=0; go to RUN.
  - Next cycle: wr_base_load=1 and rd_base_load=1, with addresses for idx 0 and NBUF-1.
  - wr_frame_done and rd_frame_req are ignored.
- RUN:
  - stop: go to IDLE, same cycle. Events arriving on that edge are ignored. Address outputs and counters hold. No strobes.
  - start while in RUN: re-initialise exactly as from IDLE (restart). Counters are not cleared.
  - start and stop in the same cycle: stop wins.
- Event update in RUN, all in one cycle. Evaluate in this order, then commit:
  1. If wr_frame_done:
     - if ready_valid was already 1, frames_dropped += 1;
     - ready_idx=wr_idx, ready_valid=1.
  2. If rd_frame_req:
     - if ready_valid (after step 1): rd_idx=ready_idx, ready_valid=0;
     - else frames_repeated += 1 and rd_idx is unchanged.
  3. If wr_frame_done: new wr_idx = lowest index in 0..NBUF-1 that is not equal to the post-update rd_idx, and not equal to the post-update ready_idx when ready_valid=1.
     - With NBUF>=3 such an index always exists.
- Simultaneous wr_frame_done and rd_frame_req: the display takes the just-completed frame (old wr_idx). The writer moves to the lowest index free of both.
- Address = base + idx*frame_bytes.
  - Use shift-add on idx; no DSP multiply.
  - 32-bit arithmetic, wrap modulo 2^32, no overflow flag.
- Strobe latency:
  - wr_base_load rises exactly 1 cycle after a committed wr_frame_done, for one cycle, with wr_base already valid.
  - rd_base_load rises exactly 1 cycle after every rd_frame_req handled in RUN, including repeats; rd_base is unchanged on a repeat.
- wr_base and rd_base are registered and hold between strobes.
- Invariant checked by assertion in RUN: wr_idx != rd_idx, and wr_idx != ready_idx whenever ready_valid=1.
- Counters saturate at 32'hFFFF_FFFF.

Optional Feature:
- Macro: FBSCHED_STATS_EN.
- Defined: frames_dropped and frames_repeated count as above.
- Undefined: both outputs are tied to 32'h0, and the counter registers and saturation logic are not built.

Test Plan:
- Reset, then start with cfg_base=32'h1000_0000, frame_bytes=32'h0004_B000 -> next cycle wr_base=32'h1000_0000 and rd_base=32'h1009_6000, both load strobes for 1 cycle, running=1.
- wr_frame_done, then rd_frame_req 5 cycles later -> ready_idx=0. wr_idx goes to 1 (rd_idx=2), wr_base=32'h1004_B000. After the read: rd_idx=0, rd_base=32'h1000_0000, counters 0.
- Two wr_frame_done with no rd_frame_req -> frames_dropped=1. Writer alternates among indices excluding rd_idx and ready_idx. Invariant never violated.
- rd_frame_req twice with no completed frame -> frames_repeated=2, rd_base_load pulses both times, rd_base unchanged.
- wr_frame_done and rd_frame_req in the same cycle with wr_idx=1, rd_idx=0 -> rd_idx=1, wr_idx=0, ready_valid=0, both strobes one cycle later.
- Assert rst_n low mid-RUN, then stop and start in the same cycle -> reset values restored immediately; stop+start leaves IDLE, running=0, no strobes.
